// File: rtl/sa_ram_fifo_ctrl_32x256.sv
// FIFO controller fronting a 32-entry single-port-per-direction RAM with a
// one-cycle read latency. A two-entry staging queue hides that latency, so
// the output side sustains one word per cycle. Total capacity is 34 words:
// 32 in RAM and 2 in staging, counting the word in flight out of the RAM.
module sa_ram_fifo_ctrl_32x256 #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_pvld,
  output logic              wr_prdy,
  input  logic [DATA_W-1:0] wr_pd,
  output logic              rd_pvld,
  input  logic              rd_prdy,
  output logic [DATA_W-1:0] rd_pd,
  output logic [4:0]        ram_wa,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_di,
  output logic [4:0]        ram_ra,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [5:0]        fifo_count,
  output logic              fifo_idle
);

  localparam logic [5:0] RAM_DEPTH = 6'd32;

  // Control state
  logic [5:0]        ram_cnt;
  logic [4:0]        wr_adr;
  logic [4:0]        rd_adr;
  logic              vld_p1;      // a RAM read was issued last cycle
  logic [1:0]        stage_cnt;

  // Staging data; entry 0 is always the head presented on rd_pd
  logic [DATA_W-1:0] stage_pd_p2 [2];

  logic              wr_accept;
  logic              pop;
  logic [2:0]        stage_occ;
  logic [1:0]        push_slot;

  // Write side: ready depends only on registered RAM occupancy
  assign wr_prdy   = (ram_cnt != RAM_DEPTH);
  assign wr_accept = wr_pvld & wr_prdy & reset_;
  assign ram_we    = wr_accept;
  assign ram_wa    = wr_adr;
  assign ram_di    = wr_pd;

  // Read side: only issue a RAM read when the staging queue is sure to have
  // room for the returning word after this cycle's pop
  assign pop       = rd_pvld & rd_prdy;
  assign stage_occ = {1'b0, stage_cnt} + {2'b0, vld_p1} - {2'b0, pop};
  assign ram_re    = (ram_cnt != 6'd0) & (stage_occ < 3'd2);
  assign ram_ra    = rd_adr;

  // The returning word lands behind whatever survives this cycle's pop
  assign push_slot = stage_cnt - {1'b0, pop};

  assign rd_pvld    = (stage_cnt != 2'd0);
  assign rd_pd      = stage_pd_p2[0];
  assign fifo_count = ram_cnt + {5'b0, vld_p1} + {4'b0, stage_cnt};
  assign fifo_idle  = (fifo_count == 6'd0);

  // Occupancy counters, addresses and the in-flight flag
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ram_cnt   <= 6'd0;
      wr_adr    <= 5'd0;
      rd_adr    <= 5'd0;
      vld_p1    <= 1'b0;
      stage_cnt <= 2'd0;
    end else begin
      ram_cnt   <= ram_cnt + {5'b0, wr_accept} - {5'b0, ram_re};
      if (wr_accept) wr_adr <= wr_adr + 5'd1;
      if (ram_re)    rd_adr <= rd_adr + 5'd1;
      vld_p1    <= ram_re;
      stage_cnt <= stage_cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  // ---- stage p2: staging queue shift on pop, fill from RAM on return ----
  // The push is written after the shift so it wins when both target entry 0.
  // ram_dout is sampled at the same edge a colliding RAM write lands, so it
  // still carries the word being read.
  always_ff @(posedge clk) begin
    if (pop)    stage_pd_p2[0] <= stage_pd_p2[1];
    if (vld_p1) stage_pd_p2[push_slot[0]] <= ram_dout;
  end

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_32x256.sv
module tb_sa_ram_fifo_ctrl_32x256;

  logic         clk = 1'b0;
  logic         reset_;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [255:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [255:0] rd_pd;
  logic [4:0]   ram_wa;
  logic         ram_we;
  logic [255:0] ram_di;
  logic [4:0]   ram_ra;
  logic         ram_re;
  logic [255:0] ram_dout;
  logic [5:0]   fifo_count;
  logic         fifo_idle;

  int n_cmp  = 0;
  int n_fail = 0;

  sa_ram_fifo_ctrl_32x256 dut (
    .clk(clk), .reset_(reset_),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
    .fifo_count(fifo_count), .fifo_idle(fifo_idle)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read address, combinational dout
  logic [255:0] mem [32];
  logic [4:0]   ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  // Scoreboard monitor: samples 1 time unit after each falling edge
  logic [255:0] exp_q [$];
  logic [255:0] exp_w;
  logic [4:0]   tot_wr;
  logic [4:0]   tot_re;
  logic         hold_v;
  logic [255:0] hold_pd;

  always @(negedge clk) begin
    #1;
    if (!reset_) begin
      exp_q.delete();
      tot_wr = '0;
      tot_re = '0;
      hold_v = 1'b0;
    end else begin
      n_cmp++; if (int'(fifo_count) !== exp_q.size()) begin n_fail++; $display("FAIL sb_count: got %0d want %0d", fifo_count, exp_q.size()); end
      n_cmp++; if (fifo_idle !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL sb_idle: got %0b want %0b", fifo_idle, exp_q.size() == 0); end
      n_cmp++; if (ram_we !== (wr_pvld & wr_prdy)) begin n_fail++; $display("FAIL sb_we: got %0b want %0b", ram_we, wr_pvld & wr_prdy); end
      if (ram_we) begin
        n_cmp++; if (ram_wa !== tot_wr) begin n_fail++; $display("FAIL sb_wa: got %0d want %0d", ram_wa, tot_wr); end
        n_cmp++; if (ram_di !== wr_pd) begin n_fail++; $display("FAIL sb_di: got %0h want %0h", ram_di, wr_pd); end
      end
      if (ram_re) begin
        n_cmp++; if (ram_ra !== tot_re) begin n_fail++; $display("FAIL sb_ra: got %0d want %0d", ram_ra, tot_re); end
      end
      if (hold_v) begin
        n_cmp++; if (rd_pvld !== 1'b1 || rd_pd !== hold_pd) begin n_fail++; $display("FAIL sb_hold: got vld=%0b pd=%0h want vld=1 pd=%0h", rd_pvld, rd_pd, hold_pd); end
      end
      if (wr_pvld && wr_prdy) begin
        exp_q.push_back(wr_pd);
        tot_wr = tot_wr + 5'd1;
      end
      if (ram_re) tot_re = tot_re + 5'd1;
      if (rd_pvld && rd_prdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_underflow: got pd=%0h want no output", rd_pd);
        end else begin
          exp_w = exp_q.pop_front();
          if (rd_pd !== exp_w) begin n_fail++; $display("FAIL sb_data: got %0h want %0h", rd_pd, exp_w); end
        end
      end
      hold_v  = rd_pvld && !rd_prdy;
      hold_pd = rd_pd;
    end
  end

  task automatic test_reset();
    reset_ = 1'b0; wr_pvld = 1'b1; wr_pd = '1; rd_prdy = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL rst_wr_prdy: got %0b want 1", wr_prdy); end
    n_cmp++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL rst_rd_pvld: got %0b want 0", rd_pvld); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %0b want 0", ram_we); end
    n_cmp++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL rst_ram_re: got %0b want 0", ram_re); end
    n_cmp++; if (fifo_count !== 6'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0b want 1", fifo_idle); end
    @(negedge clk); wr_pvld = 1'b0;
    @(negedge clk); reset_ = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); wr_pvld = 1'b1; wr_pd = {32{8'hA5}}; rd_prdy = 1'b1; #2;
    n_cmp++; if (ram_we !== 1'b1 || ram_wa !== 5'd0) begin n_fail++; $display("FAIL single_c0_we: got we=%0b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    @(negedge clk); wr_pvld = 1'b0; #2;
    n_cmp++; if (ram_re !== 1'b1 || ram_ra !== 5'd0) begin n_fail++; $display("FAIL single_c1_re: got re=%0b ra=%0d want re=1 ra=0", ram_re, ram_ra); end
    @(negedge clk); #2;
    n_cmp++; if (rd_pvld !== 1'b0 || fifo_count !== 6'd1) begin n_fail++; $display("FAIL single_c2: got vld=%0b cnt=%0d want vld=0 cnt=1", rd_pvld, fifo_count); end
    @(negedge clk); #2;
    n_cmp++; if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL single_c3_vld: got %0b want 1", rd_pvld); end
    n_cmp++; if (rd_pd !== {32{8'hA5}}) begin n_fail++; $display("FAIL single_c3_pd: got %0h want %0h", rd_pd, {32{8'hA5}}); end
    @(negedge clk); #2;
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL single_c4_idle: got %0b want 1", fifo_idle); end
  endtask

  task automatic test_fill();
    int idx = 0;
    int pops = 0;
    rd_prdy = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); wr_pvld = (idx < 41); wr_pd = 256'(idx); #2;
      if (wr_pvld && wr_prdy) idx++;
    end
    n_cmp++; if (idx !== 34) begin n_fail++; $display("FAIL fill_accepted: got %0d want 34", idx); end
    n_cmp++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL fill_wr_prdy: got %0b want 0", wr_prdy); end
    n_cmp++; if (fifo_count !== 6'd34) begin n_fail++; $display("FAIL fill_count: got %0d want 34", fifo_count); end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b1; #2;
      if (rd_pvld) begin
        n_cmp++; if (rd_pd !== 256'(pops)) begin n_fail++; $display("FAIL fill_order: got %0h want %0h", rd_pd, pops); end
        pops++;
      end
    end
    n_cmp++; if (pops !== 34) begin n_fail++; $display("FAIL fill_drained: got %0d want 34", pops); end
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL fill_idle: got %0b want 1", fifo_idle); end
  endtask

  task automatic test_full_wrap();
    int wcount = 0;
    int acc = 0;
    int pops = 0;
    rd_prdy = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); wr_pvld = 1'b1; wr_pd = 256'(1000 + wcount); #2;
      if (wr_prdy) wcount++;
    end
    n_cmp++; if (wcount !== 34) begin n_fail++; $display("FAIL wrap_fill: got %0d want 34", wcount); end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 256'(1000 + wcount); #2;
      if (wr_prdy) wcount++;
      if (c >= 1 && wr_prdy) acc++;
      if (c >= 1 && rd_pvld) pops++;
    end
    n_cmp++; if (acc !== 99) begin n_fail++; $display("FAIL wrap_wr_rate: got %0d want 99", acc); end
    n_cmp++; if (pops !== 99) begin n_fail++; $display("FAIL wrap_rd_rate: got %0d want 99", pops); end
    for (int c = 0; c < 60 && !fifo_idle; c++) begin
      @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b1; #2;
    end
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL wrap_drain_timeout: got idle=%0b want 1", fifo_idle); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [255:0] cur;
    cur = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int c = 0; c < 60000 && idx < 10000; c++) begin
      @(negedge clk);
      wr_pvld = $urandom_range(0, 1) == 1;
      rd_prdy = $urandom_range(0, 1) == 1;
      wr_pd   = cur;
      #2;
      if (wr_pvld && wr_prdy) begin
        idx++;
        cur = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    n_cmp++; if (idx !== 10000) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 10000", idx); end
    for (int c = 0; c < 100 && !fifo_idle; c++) begin
      @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b1; #2;
    end
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL bp_drain_timeout: got idle=%0b want 1", fifo_idle); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen = 1'b0;
    rd_prdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); wr_pvld = (n < 20); wr_pd = 256'(200 + n); #2;
      if (wr_pvld && wr_prdy) n++;
    end
    n_cmp++; if (fifo_count !== 6'd20) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 20", fifo_count); end
    // one pop plus one write: a RAM read is issued, leaving a word in flight
    @(negedge clk); wr_pvld = 1'b1; wr_pd = 256'd500; rd_prdy = 1'b1; #2;
    @(negedge clk); wr_pvld = 1'b1; wr_pd = 256'd501; rd_prdy = 1'b0; #2;
    n_cmp++; if (fifo_count !== 6'd20) begin n_fail++; $display("FAIL mid_inflight_count: got %0d want 20", fifo_count); end
    reset_ = 1'b0;
    #1;
    n_cmp++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL mid_wr_prdy: got %0b want 1", wr_prdy); end
    n_cmp++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_rd_pvld: got %0b want 0", rd_pvld); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_ram_we: got %0b want 0", ram_we); end
    n_cmp++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL mid_ram_re: got %0b want 0", ram_re); end
    n_cmp++; if (fifo_count !== 6'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %0b want 1", fifo_idle); end
    @(negedge clk); wr_pvld = 1'b0;
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk); wr_pvld = 1'b1; wr_pd = 256'd1; rd_prdy = 1'b1; #2;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); wr_pvld = 1'b0; #2;
      if (rd_pvld) begin
        seen = 1'b1;
        n_cmp++; if (rd_pd !== 256'd1) begin n_fail++; $display("FAIL mid_first_word: got %0h want 1", rd_pd); end
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_first_timeout: got no rd_pvld want word 1"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_wrap();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
